// File: rtl/vga_timing_gen_param.sv
// vga_timing_gen_param
// Parametrised raster timing generator. Free-running pixel/line counters
// advance on pixel_clock whenever pix_en is high. Sync, blank and the
// line/frame start strobes are decoded from the counters and then delayed
// PIPE_DLY enabled cycles so they line up with downstream pixel pipelines.
//
// Ports:
//   pixel_clock   in   rising-edge clock for all logic
//   reset         in   synchronous active-high reset (priority over pix_en)
//   pix_en        in   pixel advance enable; low freezes the whole block
//   pixel_count   out  current pixel in line, 0..H_TOTAL-1
//   line_count    out  current line in frame, 0..V_TOTAL-1
//   subchar_pixel out  pixel position inside a character cell
//   subchar_line  out  line position inside a character cell
//   char_column   out  character column (low 7 bits)
//   char_line     out  character row (low 7 bits)
//   h_synch       out  horizontal sync, delayed PIPE_DLY cycles
//   v_synch       out  vertical sync, delayed PIPE_DLY cycles
//   blank         out  high outside the active area, delayed PIPE_DLY cycles
//   line_start    out  pulse at pixel 0 of each line, delayed PIPE_DLY cycles
//   frame_start   out  pulse at pixel 0 of line 0, delayed PIPE_DLY cycles
module vga_timing_gen_param #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 40,
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 88,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 23,
  parameter int H_POL       = 1,
  parameter int V_POL       = 1,
  parameter int CHAR_W_LOG2 = 3,
  parameter int CHAR_H_LOG2 = 3,
  parameter int PIPE_DLY    = 1,
  parameter int HW          = 11,
  parameter int VW          = 10
) (
  input  logic                   pixel_clock,
  input  logic                   reset,
  input  logic                   pix_en,
  output logic [HW-1:0]          pixel_count,
  output logic [VW-1:0]          line_count,
  output logic [CHAR_W_LOG2-1:0] subchar_pixel,
  output logic [CHAR_H_LOG2-1:0] subchar_line,
  output logic [6:0]             char_column,
  output logic [6:0]             char_line,
  output logic                   h_synch,
  output logic                   v_synch,
  output logic                   blank,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Elaboration-time sanity checks on the configuration.
  if (H_TOTAL > (1 << HW)) begin : g_hw_too_small
    $error("vga_timing_gen_param: H_TOTAL does not fit in HW bits");
  end
  if (V_TOTAL > (1 << VW)) begin : g_vw_too_small
    $error("vga_timing_gen_param: V_TOTAL does not fit in VW bits");
  end
  if ((PIPE_DLY < 1) || (PIPE_DLY > 8)) begin : g_bad_dly
    $error("vga_timing_gen_param: PIPE_DLY must be 1..8");
  end

  // Inclusive end points keep every constant below the total, so they always fit.
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS      = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE      = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_ONE     = HW'(1);
  localparam logic [HW-1:0] H_ZERO    = HW'(0);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS      = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE      = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_ONE     = VW'(1);
  localparam logic [VW-1:0] V_ZERO    = VW'(0);

  localparam logic HS_ON  = (H_POL != 0) ? 1'b1 : 1'b0;
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_ON  = (V_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_OFF = ~VS_ON;

  // Pipeline word layout: {hsync, vsync, blank, line_start, frame_start}.
  localparam logic [4:0] PIPE_RST = {HS_OFF, VS_OFF, 1'b1, 1'b0, 1'b0};

  logic [HW-1:0] r_pixel_count;
  logic [VW-1:0] r_line_count;
  logic [4:0]    r_pipe [PIPE_DLY];

  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_blank;
  logic          w_line_start;
  logic          w_frame_start;
  logic [4:0]    w_dec;

  // Decode timing signals from the current counter value.
  always_comb begin
    w_hs_act      = (r_pixel_count >= H_SS) && (r_pixel_count <= H_SE);
    w_vs_act      = (r_line_count >= V_SS) && (r_line_count <= V_SE);
    w_blank       = (r_pixel_count >= H_ACT) || (r_line_count >= V_ACT);
    w_line_start  = (r_pixel_count == H_ZERO);
    w_frame_start = (r_pixel_count == H_ZERO) && (r_line_count == V_ZERO);
    w_dec         = {(w_hs_act ? HS_ON : HS_OFF),
                     (w_vs_act ? VS_ON : VS_OFF),
                     w_blank, w_line_start, w_frame_start};
  end

  // Counters and the decode delay chain; everything holds while pix_en is low.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_pixel_count <= H_ZERO;
      r_line_count  <= V_ZERO;
      for (int i = 0; i < PIPE_DLY; i++) begin
        r_pipe[i] <= PIPE_RST;
      end
    end else if (pix_en) begin
      if (r_pixel_count == H_LAST) begin
        r_pixel_count <= H_ZERO;
        if (r_line_count == V_LAST) begin
          r_line_count <= V_ZERO;
        end else begin
          r_line_count <= r_line_count + V_ONE;
        end
      end else begin
        r_pixel_count <= r_pixel_count + H_ONE;
      end
      r_pipe[0] <= w_dec;
      for (int i = 1; i < PIPE_DLY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign pixel_count   = r_pixel_count;
  assign line_count    = r_line_count;
  // Character fields are plain slices of the registered counters (no extra latency).
  assign subchar_pixel = CHAR_W_LOG2'(r_pixel_count);
  assign subchar_line  = CHAR_H_LOG2'(r_line_count);
  assign char_column   = 7'(r_pixel_count >> CHAR_W_LOG2);
  assign char_line     = 7'(r_line_count >> CHAR_H_LOG2);

  assign h_synch       = r_pipe[PIPE_DLY-1][4];
  assign v_synch       = r_pipe[PIPE_DLY-1][3];
  assign blank         = r_pipe[PIPE_DLY-1][2];
  assign line_start    = r_pipe[PIPE_DLY-1][1];
  assign frame_start   = r_pipe[PIPE_DLY-1][0];

endmodule

// File: tb/tb_vga_timing_gen_param.sv
module tb_vga_timing_gen_param;

  // Small raster: H 8/2/3/2 -> 15 pixels, V 4/1/2/1 -> 8 lines, 120 cycles per frame.
  localparam int HT = 15;
  localparam int VT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b1;

  always #5 clk = ~clk;

  // Instance A: active-high syncs, one-cycle delay, 3/3 character cells.
  logic [4:0] a_pix;
  logic [3:0] a_line;
  logic [2:0] a_sp, a_sl;
  logic [6:0] a_cc, a_cl;
  logic       a_hs, a_vs, a_bl, a_ls, a_fs;

  // Instance B: active-low syncs, three-cycle delay, 2/1 cells, tight counter widths.
  logic [3:0] b_pix;
  logic [2:0] b_line;
  logic [1:0] b_sp;
  logic [0:0] b_sl;
  logic [6:0] b_cc, b_cl;
  logic       b_hs, b_vs, b_bl, b_ls, b_fs;

  vga_timing_gen_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1), .V_POL(1), .CHAR_W_LOG2(3), .CHAR_H_LOG2(3),
    .PIPE_DLY(1), .HW(5), .VW(4)
  ) u_a (
    .pixel_clock(clk), .reset(reset), .pix_en(pix_en),
    .pixel_count(a_pix), .line_count(a_line),
    .subchar_pixel(a_sp), .subchar_line(a_sl),
    .char_column(a_cc), .char_line(a_cl),
    .h_synch(a_hs), .v_synch(a_vs), .blank(a_bl),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .CHAR_W_LOG2(2), .CHAR_H_LOG2(1),
    .PIPE_DLY(3), .HW(4), .VW(3)
  ) u_b (
    .pixel_clock(clk), .reset(reset), .pix_en(pix_en),
    .pixel_count(b_pix), .line_count(b_line),
    .subchar_pixel(b_sp), .subchar_line(b_sl),
    .char_column(b_cc), .char_line(b_cl),
    .h_synch(b_hs), .v_synch(b_vs), .blank(b_bl),
    .line_start(b_ls), .frame_start(b_fs)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: n = enabled cycles since the last reset edge; counters show n mod frame.
  int n     = 0;
  bit valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      n     <= 0;
      valid <= 1'b1;
    end else if (pix_en) begin
      n <= n + 1;
    end
  end

  // Expected {hs, vs, blank, line_start, frame_start} after d enabled cycles of delay.
  function automatic logic [4:0] exp_out(input int cnt, input int d, input bit hpol, input bit vpol);
    int  k, p, l;
    bit  hs, vs;
    if (cnt < d) return {~hpol, ~vpol, 1'b1, 1'b0, 1'b0};
    k  = cnt - d;
    p  = k % HT;
    l  = (k / HT) % VT;
    hs = (p >= 10) && (p <= 12);
    vs = (l >= 5) && (l <= 6);
    return {(hs ? hpol : ~hpol), (vs ? vpol : ~vpol),
            ((p >= 8) || (l >= 4)), (p == 0), ((p == 0) && (l == 0))};
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (valid) begin
      logic [4:0] ea, eb;
      int p, l;
      p  = n % HT;
      l  = (n / HT) % VT;
      ea = exp_out(n, 1, 1'b1, 1'b1);
      eb = exp_out(n, 3, 1'b0, 1'b0);
      chk("a_pixel_count", a_pix, p);
      chk("a_line_count", a_line, l);
      chk("a_char", {a_cc, a_cl, a_sp, a_sl}, {7'(p >> 3), 7'(l >> 3), 3'(p % 8), 3'(l % 8)});
      chk("a_decoded", {a_hs, a_vs, a_bl, a_ls, a_fs}, ea);
      chk("b_pixel_count", b_pix, p);
      chk("b_line_count", b_line, l);
      chk("b_char", {b_cc, b_cl, b_sp, b_sl}, {7'(p >> 2), 7'(l >> 1), 2'(p % 4), 1'(l % 2)});
      chk("b_decoded", {b_hs, b_vs, b_bl, b_ls, b_fs}, eb);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int a_hs_cnt, a_vs_cnt, a_unbl_cnt, a_ls_cnt, a_fs_cnt, b_hs_low_cnt, en_hs_cnt;
  bit was_en;

  initial begin
    // Reset for three cycles.
    reset  = 1'b1;
    pix_en = 1'b1;
    repeat (3) step();
    chk("rst_pixel_count", a_pix, 0);
    chk("rst_line_count", a_line, 0);
    chk("rst_a_blank", a_bl, 1);
    chk("rst_a_hsync_idle", a_hs, 0);
    chk("rst_a_vsync_idle", a_vs, 0);
    chk("rst_b_hsync_idle", b_hs, 1);
    chk("rst_b_vsync_idle", b_vs, 1);
    chk("rst_b_frame_start", b_fs, 0);
    reset = 1'b0;

    // One full frame (n = 1..120), tallying literal expectations.
    a_hs_cnt = 0; a_vs_cnt = 0; a_unbl_cnt = 0; a_ls_cnt = 0; a_fs_cnt = 0; b_hs_low_cnt = 0;
    for (int i = 1; i <= 120; i++) begin
      step();
      a_hs_cnt     += int'(a_hs);
      a_vs_cnt     += int'(a_vs);
      a_unbl_cnt   += int'(!a_bl);
      a_ls_cnt     += int'(a_ls);
      a_fs_cnt     += int'(a_fs);
      b_hs_low_cnt += int'(!b_hs);
      if (i == 1)  chk("a_first_frame_start", a_fs, 1);
      if (i == 3)  chk("b_first_frame_start", b_fs, 1);
      if (i == 10) chk("a_hsync_before", a_hs, 0);
      if (i == 11) chk("a_hsync_rise", a_hs, 1);
      if (i == 12) chk("b_hsync_before", b_hs, 1);
      if (i == 13) chk("b_hsync_fall", b_hs, 0);
      if (i == 14) chk("a_pixel_wrap", a_pix, 14);
      if (i == 15) chk("a_line_inc", {27'd0, a_line, a_pix}, {4'd1, 5'd0});
    end
    chk("a_hsync_cycles_per_frame", a_hs_cnt, 24);
    chk("a_vsync_cycles_per_frame", a_vs_cnt, 30);
    chk("a_unblank_cycles_per_frame", a_unbl_cnt, 32);
    chk("a_line_starts_per_frame", a_ls_cnt, 8);
    chk("a_frame_starts_per_frame", a_fs_cnt, 1);
    chk("b_hsync_low_cycles_per_frame", b_hs_low_cnt, 24);

    // Pause two cycles inside the sync window; width over enabled cycles stays 3.
    en_hs_cnt = 0;
    repeat (11) begin
      step();
      en_hs_cnt += int'(a_hs);
    end
    pix_en = 1'b0;
    repeat (2) begin
      step();
      chk("pause_pixel_count", a_pix, 11);
      chk("pause_a_hsync", a_hs, 1);
    end
    pix_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      was_en = pix_en;
      step();
      if (was_en) en_hs_cnt += int'(a_hs);
    end
    chk("a_hsync_enabled_width", en_hs_cnt, 3);

    // Advance to (p=6, l=2) and apply a one-cycle reset.
    repeat (16) step();
    chk("pre_reset_pos", {27'd0, a_line, a_pix}, {4'd2, 5'd6});
    reset = 1'b1;
    step();
    chk("midrst_counters", {27'd0, a_line, a_pix}, 0);
    chk("midrst_a_blank", a_bl, 1);
    chk("midrst_a_syncs", {a_hs, a_vs}, 0);
    chk("midrst_b_syncs", {b_hs, b_vs}, 3);
    reset = 1'b0;
    step();
    chk("post_rst_a_frame_start", a_fs, 1);
    chk("post_rst_b_frame_start_early", b_fs, 0);
    step();
    chk("post_rst_a_no_repulse", a_fs, 0);
    step();
    chk("post_rst_b_frame_start", b_fs, 1);

    // Irregular enable pattern over more than a frame; per-cycle model checks it.
    for (int i = 0; i < 200; i++) begin
      pix_en = ((i % 5) != 2) && ((i % 7) != 4);
      step();
    end
    pix_en = 1'b1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
